// File: rtl/ntt_stage_ctrl_if.sv
// Host <-> NTT stage sequencer bus. Defining NTT_CTRL_PERF_EN adds the perf_cycles counter output.
// master: the sequencer (drives issue/write-back status); slave: the host (drives start/hold).
interface ntt_stage_ctrl_if #(
  parameter int LOGN = 8,
  parameter int AW   = LOGN,
  parameter int SW   = (LOGN >= 2) ? $clog2(LOGN) : 1
);
  logic          start;
  logic          hold;
  logic          busy;
  logic          done;
  logic [SW-1:0] stage;
  logic          bf_valid;
  logic [AW-1:0] addr_a;
  logic [AW-1:0] addr_b;
  logic [AW-2:0] tw_idx;
  logic          wb_valid;
  logic [AW-1:0] wb_addr_a;
  logic [AW-1:0] wb_addr_b;
`ifdef NTT_CTRL_PERF_EN
  logic [31:0]   perf_cycles;

  modport master (
    input  start, hold,
    output busy, done, stage, bf_valid, addr_a, addr_b, tw_idx,
           wb_valid, wb_addr_a, wb_addr_b, perf_cycles
  );
  modport slave (
    output start, hold,
    input  busy, done, stage, bf_valid, addr_a, addr_b, tw_idx,
           wb_valid, wb_addr_a, wb_addr_b, perf_cycles
  );
`else
  modport master (
    input  start, hold,
    output busy, done, stage, bf_valid, addr_a, addr_b, tw_idx,
           wb_valid, wb_addr_a, wb_addr_b
  );
  modport slave (
    output start, hold,
    input  busy, done, stage, bf_valid, addr_a, addr_b, tw_idx,
           wb_valid, wb_addr_a, wb_addr_b
  );
`endif
endinterface

// File: rtl/ntt_stage_ctrl.sv
// In-place DIF (Gentleman-Sande) NTT sequencer: one butterfly per cycle, drains the butterfly
// pipeline between stages. Optional cycle counter under NTT_CTRL_PERF_EN.
module ntt_stage_ctrl #(
  parameter int N      = 256,
  parameter int LOGN   = 8,
  parameter int AW     = 8,
  parameter int BF_LAT = 4
) (
  input logic              clk,
  input logic              reset,
  ntt_stage_ctrl_if.master bus
);
  localparam int SW = (LOGN >= 2) ? $clog2(LOGN) : 1;
  localparam int JW = AW - 1;
  localparam int DW = $clog2(BF_LAT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [AW-1:0] b;
  } wb_addr_t;

  state_t        state, state_nxt;
  logic [JW-1:0] j;
  logic [SW-1:0] s;
  logic [DW-1:0] dcnt;

  logic issue, last_bf, last_stage, drain_end;

  assign issue      = (state == ISSUE) && !bus.hold;
  assign last_bf    = (j == JW'(N/2 - 1));
  assign last_stage = (s == SW'(LOGN - 1));
  assign drain_end  = (dcnt == DW'(BF_LAT - 1));

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = ISSUE;
      ISSUE:   if (issue && last_bf) state_nxt = DRAIN;
      DRAIN:   if (drain_end) state_nxt = last_stage ? DONE : ISSUE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // j is cleared explicitly on every stage boundary; it never wraps by overflow.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      j     <= '0;
      s     <= '0;
      dcnt  <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (bus.start) begin
          j    <= '0;
          s    <= '0;
          dcnt <= '0;
        end
        ISSUE: if (issue) begin
          if (last_bf) dcnt <= '0;
          else         j    <= j + 1'b1;
        end
        DRAIN: begin
          dcnt <= dcnt + 1'b1;
          if (drain_end) begin
            dcnt <= '0;
            j    <= '0;
            if (!last_stage) s <= s + 1'b1;
          end
        end
        DONE:    s <= '0;
        default: ;
      endcase
    end
  end

  // len = N>>(s+1) is a power of two, so k = j mod len is a mask and
  // g*2*len is the masked-off high part of j shifted up by one.
  logic [JW-1:0] mask_j, k;
  logic [AW-1:0] a_cur, b_cur;

  assign mask_j = {JW{1'b1}} >> s;
  assign k      = j & mask_j;
  assign a_cur  = {j & ~mask_j, 1'b0} | {1'b0, k};
  assign b_cur  = a_cur | (AW'(N/2) >> s);

  assign bus.busy     = (state != IDLE);
  assign bus.done     = (state == DONE);
  assign bus.stage    = s;
  assign bus.bf_valid = issue;
  assign bus.addr_a   = issue ? a_cur : '0;
  assign bus.addr_b   = issue ? b_cur : '0;
  assign bus.tw_idx   = issue ? (k << s) : '0;

  // Write-back delay line; reset flushes anything in flight.
  logic [BF_LAT:1] vld_pipe;
  wb_addr_t        addr_pipe [BF_LAT:1];

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_pipe <= '0;
      for (int i = 1; i <= BF_LAT; i++) addr_pipe[i] <= '0;
    end else begin
      vld_pipe[1]  <= issue;
      addr_pipe[1] <= '{a: bus.addr_a, b: bus.addr_b};
      for (int i = 2; i <= BF_LAT; i++) begin
        vld_pipe[i]  <= vld_pipe[i-1];
        addr_pipe[i] <= addr_pipe[i-1];
      end
    end
  end

  assign bus.wb_valid  = vld_pipe[BF_LAT];
  assign bus.wb_addr_a = addr_pipe[BF_LAT].a;
  assign bus.wb_addr_b = addr_pipe[BF_LAT].b;

`ifdef NTT_CTRL_PERF_EN
  logic [31:0] perf;

  always_ff @(posedge clk) begin
    if (reset)                 perf <= '0;
    else if (state == IDLE) begin
      if (bus.start)           perf <= '0;
    end else if (perf != 32'hFFFF_FFFF)
                               perf <= perf + 1'b1;
  end

  assign bus.perf_cycles = perf;
`endif
endmodule

// File: tb/tb_ntt_stage_ctrl.sv
// Scoreboard bench for ntt_stage_ctrl (N=8, LOGN=3, BF_LAT=2); perf checks under NTT_CTRL_PERF_EN.
module tb_ntt_stage_ctrl;
  localparam int N = 8, LOGN = 3, AW = 3, BF_LAT = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  ntt_stage_ctrl_if #(.LOGN(LOGN), .AW(AW)) bus ();

  ntt_stage_ctrl #(.N(N), .LOGN(LOGN), .AW(AW), .BF_LAT(BF_LAT)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct {
    int cyc;
    int a, b, tw, stg;
  } ev_t;

  ev_t exp_bf[$];
  ev_t exp_wb[$];
  int  exp_done[$];

  // Hand-computed butterfly order for N=8: stage0, stage1, stage2.
  int A_T  [12] = '{0,1,2,3, 0,1,4,5, 0,2,4,6};
  int B_T  [12] = '{4,5,6,7, 2,3,6,7, 1,3,5,7};
  int TW_T [12] = '{0,1,2,3, 0,2,0,2, 0,0,0,0};

  int cyc = 0;
  int nchk = 0, nerr = 0;
  int base;
  bit mon_en = 1'b0;
  ev_t e;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int got, input int req);
    nchk++;
    if (got != req) begin
      nerr++;
      $display("FAIL %s @cyc %0d: got %0d, required %0d", nm, cyc, got, req);
    end
  endtask

  // Butterfly i issues at 1 + 6*stage + slot; shift delays everything after the first.
  task automatic push_run(input int b0, input int shift, input int cutoff);
    for (int i = 0; i < 12; i++) begin
      int c;
      c = b0 + 1 + 6*(i/4) + (i%4) + ((i > 0) ? shift : 0);
      if (c <= cutoff)
        exp_bf.push_back('{cyc: c, a: A_T[i], b: B_T[i], tw: TW_T[i], stg: i/4});
      if (c + BF_LAT <= cutoff)
        exp_wb.push_back('{cyc: c + BF_LAT, a: A_T[i], b: B_T[i], tw: 0, stg: 0});
    end
    if (b0 + 19 + shift <= cutoff) exp_done.push_back(b0 + 19 + shift);
  endtask

  task automatic goto(input int rel);
    while (cyc < base + rel) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk_drained(input string nm);
    chk({nm, "_bf_left"}, exp_bf.size(), 0);
    chk({nm, "_wb_left"}, exp_wb.size(), 0);
    chk({nm, "_done_left"}, exp_done.size(), 0);
  endtask

  task automatic chk_quiet(input string nm);
    chk({nm, "_busy"}, int'(bus.busy), 0);
    chk({nm, "_done"}, int'(bus.done), 0);
    chk({nm, "_bf_valid"}, int'(bus.bf_valid), 0);
    chk({nm, "_wb_valid"}, int'(bus.wb_valid), 0);
    chk({nm, "_stage"}, int'(bus.stage), 0);
    chk({nm, "_addr"}, int'({bus.addr_a, bus.addr_b, bus.tw_idx}), 0);
`ifdef NTT_CTRL_PERF_EN
    chk({nm, "_perf"}, int'(bus.perf_cycles), 0);
`endif
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents an event.
  always @(negedge clk) if (mon_en) begin
    if (bus.bf_valid) begin
      if (exp_bf.size() == 0) begin
        nchk++; nerr++;
        $display("FAIL bf_unexpected @cyc %0d: got a=%0d b=%0d, required no issue", cyc, bus.addr_a, bus.addr_b);
      end else begin
        e = exp_bf.pop_front();
        chk("bf_cycle", cyc, e.cyc);
        chk("bf_addr_a", int'(bus.addr_a), e.a);
        chk("bf_addr_b", int'(bus.addr_b), e.b);
        chk("bf_tw_idx", int'(bus.tw_idx), e.tw);
        chk("bf_stage", int'(bus.stage), e.stg);
      end
    end else begin
      chk("idle_addr_zero", int'({bus.addr_a, bus.addr_b, bus.tw_idx}), 0);
    end
    if (bus.wb_valid) begin
      if (exp_wb.size() == 0) begin
        nchk++; nerr++;
        $display("FAIL wb_unexpected @cyc %0d: got a=%0d b=%0d, required no write", cyc, bus.wb_addr_a, bus.wb_addr_b);
      end else begin
        e = exp_wb.pop_front();
        chk("wb_cycle", cyc, e.cyc);
        chk("wb_addr_a", int'(bus.wb_addr_a), e.a);
        chk("wb_addr_b", int'(bus.wb_addr_b), e.b);
      end
    end
    if (bus.done) begin
      if (exp_done.size() == 0) begin
        nchk++; nerr++;
        $display("FAIL done_unexpected @cyc %0d: got done=1, required 0", cyc);
      end else begin
        chk("done_cycle", cyc, exp_done.pop_front());
      end
    end
  end

  initial begin
    bus.start = 1'b0;
    bus.hold  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_quiet("reset");
    reset  = 1'b0;
    mon_en = 1'b1;

    // Run 1: plain transform, write-back timing.
    base = cyc;
    bus.start = 1'b1;
    push_run(base, 0, 1 << 30);
    goto(1);  bus.start = 1'b0;
    goto(20);
`ifdef NTT_CTRL_PERF_EN
    chk("run1_perf", int'(bus.perf_cycles), 19);
`endif
    chk("run1_idle_busy", int'(bus.busy), 0);
    goto(24);
`ifdef NTT_CTRL_PERF_EN
    chk("run1_perf_hold", int'(bus.perf_cycles), 19);
`endif
    chk_drained("run1");

    // Run 3: hold in cycles 2-3 shifts everything after the first issue by 2.
    base = cyc;
    bus.start = 1'b1;
    push_run(base, 2, 1 << 30);
    goto(1);  bus.start = 1'b0;
`ifdef NTT_CTRL_PERF_EN
    chk("run3_perf_clear", int'(bus.perf_cycles), 0);
`endif
    goto(2);  bus.hold = 1'b1;
    goto(4);  bus.hold = 1'b0;
    goto(22);
`ifdef NTT_CTRL_PERF_EN
    chk("run3_perf", int'(bus.perf_cycles), 21);
`endif
    goto(24);
    chk_drained("run3");

    // Run 4: start while busy, hold in DRAIN and start in DONE are ignored; start in IDLE restarts.
    base = cyc;
    bus.start = 1'b1;
    push_run(base, 0, 1 << 30);
    goto(1);  bus.start = 1'b0;
    goto(5);  bus.start = 1'b1; bus.hold = 1'b1;
    goto(6);  bus.start = 1'b0; bus.hold = 1'b0;
    goto(19); bus.start = 1'b1;
    goto(20);
`ifdef NTT_CTRL_PERF_EN
    chk("run4_perf", int'(bus.perf_cycles), 19);
`endif
    push_run(base + 20, 0, 1 << 30);
    goto(21); bus.start = 1'b0;
`ifdef NTT_CTRL_PERF_EN
    chk("run4b_perf_clear", int'(bus.perf_cycles), 0);
`endif
    goto(44);
    chk_drained("run4");

    // Run 5: reset at cycle 8 aborts; in-flight writes dropped, no done.
    base = cyc;
    bus.start = 1'b1;
    push_run(base, 0, base + 8);
    goto(1);  bus.start = 1'b0;
    goto(8);  reset = 1'b1;
    goto(9);  reset = 1'b0;
    chk_quiet("abort");
    goto(10);
    chk("abort_wb1", int'(bus.wb_valid), 0);
    goto(12); bus.start = 1'b1;
    push_run(base + 12, 0, 1 << 30);
    goto(13); bus.start = 1'b0;
    goto(36);
    chk_drained("run5");

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end
endmodule
